// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath.
// Provides default array geometry, the output-collector FSM state type and the
// signed result element type.
package systolic_pkg;

  localparam int unsigned DimDef   = 8;
  localparam int unsigned BitsCDef = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } memc_state_t;

  typedef logic signed [BitsCDef-1:0] elem_t;

endpackage

// File: rtl/deskew_lane.sv
// One lane of the output deskew: an en-gated shift register of DEPTH stages.
// DEPTH == 0 degenerates to a plain wire.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears all stages
//   en     shift strobe
//   d      lane input
//   q      lane output, d delayed by DEPTH en-strobes
module deskew_lane #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned BITS  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, en};
  end else begin : g_sr
    logic [DEPTH-1:0][BITS-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q <= '0;
      end else if (en) begin
        sr_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/memc_deskew.sv
// Output deskew / tile collector for the systolic array.
// Realigns diagonally skewed result lanes into whole rows, stores a DIM x DIM
// tile and drains it row by row over a valid/ready stream.
// Optional build macro MEMC_DESKEW_RELU_EN: negative elements are forced to 0 on
// Cout (buffer contents untouched).
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        begin collecting a tile (IDLE only)
//   en           array advance strobe, sampled in FILL
//   Cin          skewed result lanes
//   out_valid    Cout / out_row_idx hold a valid row
//   out_ready    consumer accepts row
//   out_row_idx  index of row on Cout
//   Cout         aligned result row
//   busy         state != IDLE
//   done         one-cycle pulse after the last row handshake
module memc_deskew
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_C = BitsCDef,
  parameter int unsigned DIM    = DimDef
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          en,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DIM)-1:0]        out_row_idx,
  output logic [DIM-1:0][BITS_C-1:0]    Cout,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned KW = $clog2(2 * DIM - 1);
  localparam int unsigned RW = $clog2(DIM);
  localparam logic [KW-1:0] KLast    = KW'(2 * DIM - 2);
  localparam logic [KW-1:0] KFirstWr = KW'(DIM - 1);
  localparam logic [RW-1:0] RLast    = RW'(DIM - 1);

  memc_state_t                    state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic [RW-1:0]                  row_q, row_d;
  logic                           done_q, done_d;
  logic [DIM-1:0][DIM-1:0][BITS_C-1:0] buf_q;
  logic [DIM-1:0][BITS_C-1:0]     aligned;
  logic                           shift;
  logic [RW-1:0]                  wr_row;

  assign shift  = en && (state_q == FILL);
  // Aligned row r appears at en-count k = r + DIM - 1.
  assign wr_row = RW'(k_q - KFirstWr);

  // Lane j is delayed DIM-1-j stages so that all lanes of a row line up.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    deskew_lane #(
      .DEPTH (DIM - 1 - j),
      .BITS  (BITS_C)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (shift),
      .d     (Cin[j]),
      .q     (aligned[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          k_d     = '0;
        end
      end
      FILL: begin
        if (en) begin
          if (k_q == KLast) begin
            state_d = DRAIN;
            row_d   = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // out_valid is implied by DRAIN, so out_ready alone marks a handshake.
        if (out_ready) begin
          if (row_q == RLast) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (shift && (k_q >= KFirstWr)) begin
      buf_q[wr_row] <= aligned;
    end
  end

  assign out_valid   = (state_q == DRAIN);
  assign out_row_idx = row_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  // Cout is zero outside DRAIN so nothing stale leaks onto the stream.
  always_comb begin
    Cout = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < DIM; j++) begin
`ifdef MEMC_DESKEW_RELU_EN
        Cout[j] = buf_q[row_q][j][BITS_C-1] ? '0 : buf_q[row_q][j];
`else
        Cout[j] = buf_q[row_q][j];
`endif
      end
    end
  end

endmodule

// File: tb/tb_memc_deskew.sv
module tb_memc_deskew;
  import systolic_pkg::*;

  localparam int DIM = 4;
  localparam int BW  = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic                     en;
  logic [DIM-1:0][BW-1:0]   Cin;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_row_idx;
  logic [DIM-1:0][BW-1:0]   Cout;
  logic                     busy;
  logic                     done;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0]          tile [DIM][DIM];
  logic [DIM-1:0][BW-1:0] row2_cap;

  always #5 clk = ~clk;

  memc_deskew #(
    .BITS_C (BW),
    .DIM    (DIM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .en          (en),
    .Cin         (Cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row_idx (out_row_idx),
    .Cout        (Cout),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference view of one output element after the optional ReLU.
  function automatic logic [BW-1:0] model_out(input logic [BW-1:0] v);
`ifdef MEMC_DESKEW_RELU_EN
    return ($signed(v) < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++)
        tile[r][j] = BW'(16 * r + j);
  endtask

  task automatic fill_random();
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++)
        tile[r][j] = BW'($urandom);
  endtask

  // Element (r,j) goes on lane j at en-count r+j; other slots carry junk.
  task automatic drive_tile(input int gap, input bit start_noise);
    for (int k = 0; k < 2 * DIM - 1; k++) begin
      for (int j = 0; j < DIM; j++) begin
        if (k - j >= 0 && k - j < DIM) Cin[j] = tile[k-j][j];
        else Cin[j] = BW'($urandom);
      end
      en    = 1'b1;
      start = start_noise;
      @(negedge clk);
      en    = 1'b0;
      start = 1'b0;
      Cin   = {DIM{BW'($urandom)}};
      repeat (gap) @(negedge clk);
    end
  endtask

  // Expects the rows in order 0..DIM-1; returns positioned on the done cycle.
  task automatic drain_check(input int stall_row, input int stall_len, input bit start_noise);
    logic [DIM-1:0][BW-1:0] exp_row;
    int cnt;
    for (int r = 0; r < DIM; r++) begin
      cnt = 0;
      while (!out_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      for (int j = 0; j < DIM; j++) exp_row[j] = model_out(tile[r][j]);
      check("out_valid", 64'(out_valid), 64'(1));
      check("row_idx", 64'(out_row_idx), 64'(r));
      check("row_data", 64'(Cout), 64'(exp_row));
      if (r == 2) row2_cap = Cout;
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          start = start_noise;
          @(negedge clk);
          start = 1'b0;
          check("held_valid", 64'(out_valid), 64'(1));
          check("held_idx", 64'(out_row_idx), 64'(r));
          check("held_data", 64'(Cout), 64'(exp_row));
        end
      end
      out_ready = 1'b1;
      start     = start_noise;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b0;
    end
    check("done_pulse", 64'(done), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
    check("valid_after", 64'(out_valid), 64'(0));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  typedef struct {
    logic [BW-1:0] c21;
    logic [BW-1:0] exp_cout1;
  } vec_t;

  vec_t vecs [4];

  initial begin
`ifdef MEMC_DESKEW_RELU_EN
    vecs[0] = '{c21: 16'hFFFB, exp_cout1: 16'h0000};
    vecs[1] = '{c21: 16'h7FFF, exp_cout1: 16'h7FFF};
    vecs[2] = '{c21: 16'h8000, exp_cout1: 16'h0000};
    vecs[3] = '{c21: 16'h0001, exp_cout1: 16'h0001};
`else
    vecs[0] = '{c21: 16'hFFFB, exp_cout1: 16'hFFFB};
    vecs[1] = '{c21: 16'h7FFF, exp_cout1: 16'h7FFF};
    vecs[2] = '{c21: 16'h8000, exp_cout1: 16'h8000};
    vecs[3] = '{c21: 16'h0001, exp_cout1: 16'h0001};
`endif

    rst_n     = 1'b0;
    start     = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    Cin       = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_idx", 64'(out_row_idx), 64'(0));
    check("rst_cout", 64'(Cout), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // en in IDLE must not start anything
    for (int i = 0; i < 3; i++) begin
      Cin = {DIM{BW'($urandom)}};
      en  = 1'b1;
      @(negedge clk);
      check("idle_en_busy", 64'(busy), 64'(0));
      check("idle_en_valid", 64'(out_valid), 64'(0));
    end
    en = 1'b0;

    // Full tile, no gaps
    fill_pattern();
    pulse_start();
    check("fill_busy", 64'(busy), 64'(1));
    drive_tile(0, 1'b0);
    drain_check(-1, 0, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_cout", 64'(Cout), 64'(0));

    // Gapped en and backpressure on row 1
    pulse_start();
    drive_tile(2, 1'b0);
    drain_check(1, 5, 1'b0);
    @(negedge clk);

    // Reset in the middle of FILL after en-count 3
    fill_random();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < DIM; j++) Cin[j] = BW'($urandom);
      en = 1'b1;
      @(negedge clk);
    end
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_cout", 64'(Cout), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_pattern();
    pulse_start();
    drive_tile(1, 1'b0);
    drain_check(-1, 0, 1'b0);

    // start noise during FILL/DRAIN, then back-to-back tile started on done
    fill_random();
    @(negedge clk);
    pulse_start();
    drive_tile(0, 1'b1);
    drain_check(2, 3, 1'b1);
    fill_random();
    pulse_start();
    check("b2b_busy", 64'(busy), 64'(1));
    drive_tile(0, 1'b0);
    drain_check(-1, 0, 1'b0);

    // Sign-bit handling on element (2,1)
    for (int v = 0; v < 4; v++) begin
      fill_random();
      tile[2][1] = vecs[v].c21;
      @(negedge clk);
      pulse_start();
      drive_tile(v % 2, 1'b0);
      drain_check(-1, 0, 1'b0);
      check("c21_out", 64'(row2_cap[1]), 64'(vecs[v].exp_cout1));
    end

    // Randomised tiles, gaps and stalls
    for (int t = 0; t < 8; t++) begin
      fill_random();
      @(negedge clk);
      pulse_start();
      drive_tile(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      drain_check(int'($urandom_range(0, DIM)), int'($urandom_range(1, 4)), 1'b0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
